// File: rtl/interrupt_controller.sv
// Interrupt flag/enable registers with request edge capture and dispatch-vector handshake.
// Read data is zero when not selected, so it can be OR-combined onto the CPU bus.
module interrupt_controller #(
  parameter logic [15:0] IF_ADDR     = 16'hFF0F,
  parameter logic [15:0] IE_ADDR     = 16'hFFFF,
  parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Enable,
  input  logic [15:0] i_Address,
  input  logic        i_Address_Out,
  input  logic [7:0]  i_Bus,
  input  logic        i_Bus_Out,
  input  logic        i_Bus_In,
  input  logic [4:0]  i_Requests,
  input  logic        i_Handle_Interrupt,
  output logic [7:0]  o_Bus,
  output logic        o_Selected,
  output logic [4:0]  o_Interrupts,
  output logic [15:0] o_Vector,
  output logic        o_Vector_Valid
);

  logic [4:0]  if_q;
  logic [7:0]  ie_q;
  logic [4:0]  req_hist;
  logic        ack_hist;
  logic [15:0] vector_q;
  logic        vector_valid_q;

  logic        hit_if;
  logic        hit_ie;
  logic        wr_if;
  logic        wr_ie;
  logic [4:0]  req_edge;
  logic [4:0]  pending;
  logic        ack_rise;
  logic        ack_found;
  logic [2:0]  ack_idx;
  logic [4:0]  ack_clear;
  logic [4:0]  if_next;

  // Index of the lowest set bit; callers qualify the result with a nonzero test.
  function automatic logic [2:0] lowest_set(input logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [15:0] vector_for(input logic [2:0] idx);
    return VECTOR_BASE + {10'b0, idx, 3'b000};
  endfunction

  assign hit_if     = i_Address_Out && (i_Address == IF_ADDR);
  assign hit_ie     = i_Address_Out && (i_Address == IE_ADDR);
  assign o_Selected = hit_if || hit_ie;

  always_comb begin
    o_Bus = 8'h00;
    if (i_Bus_In) begin
      if (hit_if)      o_Bus = {3'b111, if_q};
      else if (hit_ie) o_Bus = ie_q;
    end
  end

  assign wr_if = hit_if && i_Bus_Out;
  assign wr_ie = hit_ie && i_Bus_Out;

  assign req_edge     = i_Requests & ~req_hist;
  assign pending      = if_q & ie_q[4:0];
  assign o_Interrupts = pending;

  // Acknowledge selection uses the register values from before the edge.
  assign ack_rise  = i_Handle_Interrupt && !ack_hist;
  assign ack_found = |pending;
  assign ack_idx   = lowest_set(pending);
  assign ack_clear = (ack_rise && ack_found) ? (5'b00001 << ack_idx) : 5'b00000;

  // A CPU write overrides the ack clear; fresh request edges always win.
  assign if_next = (wr_if ? i_Bus[4:0] : (if_q & ~ack_clear)) | req_edge;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      if_q           <= 5'b0;
      ie_q           <= 8'h00;
      req_hist       <= 5'b0;
      ack_hist       <= 1'b0;
      vector_q       <= 16'h0000;
      vector_valid_q <= 1'b0;
    end else if (i_Enable) begin
      if_q     <= if_next;
      req_hist <= i_Requests;
      ack_hist <= i_Handle_Interrupt;
      if (wr_ie) ie_q <= i_Bus;
      if (ack_rise) begin
        vector_q       <= ack_found ? vector_for(ack_idx) : 16'h0000;
        vector_valid_q <= 1'b1;
      end else if (!i_Handle_Interrupt) begin
        vector_valid_q <= 1'b0;
      end
    end
  end

  assign o_Vector       = vector_q;
  assign o_Vector_Valid = vector_valid_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and randomized bench for interrupt_controller against a behavioural model.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] addr;
  logic        addr_out;
  logic [7:0]  wdata;
  logic        bus_out;
  logic        bus_in;
  logic [4:0]  req;
  logic        hi;
  logic [7:0]  rdata;
  logic        sel;
  logic [4:0]  ints;
  logic [15:0] vec;
  logic        vv;

  int pass_cnt = 0;
  int total    = 0;

  // Behavioural model state
  logic [4:0]  m_if;
  logic [7:0]  m_ie;
  logic [4:0]  m_hist;
  logic        m_ack;
  logic [15:0] m_vec;
  logic        m_vv;

  interrupt_controller dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Address(addr),
    .i_Address_Out(addr_out), .i_Bus(wdata), .i_Bus_Out(bus_out),
    .i_Bus_In(bus_in), .i_Requests(req), .i_Handle_Interrupt(hi),
    .o_Bus(rdata), .o_Selected(sel), .o_Interrupts(ints),
    .o_Vector(vec), .o_Vector_Valid(vv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Model of one clock edge, computed from the pre-edge state and inputs.
  task automatic model_edge();
    logic [4:0] edges, newif, pend;
    int n;
    if (rst) begin
      m_if = 0; m_ie = 0; m_hist = 0; m_ack = 0; m_vec = 0; m_vv = 0;
    end else if (en) begin
      edges = req & ~m_hist;
      pend  = m_if & m_ie[4:0];
      n = -1;
      for (int i = 0; i < 5; i++) if (n < 0 && pend[i]) n = i;
      newif = m_if;
      if (hi && !m_ack && n >= 0) newif[n] = 1'b0;
      if (addr_out && bus_out && addr == 16'hFF0F) newif = wdata[4:0];
      newif = newif | edges;
      if (addr_out && bus_out && addr == 16'hFFFF) m_ie = wdata;
      if (hi && !m_ack) begin
        m_vec = (n >= 0) ? 16'h0040 + 16'(8 * n) : 16'h0000;
        m_vv  = 1'b1;
      end else if (!hi) begin
        m_vv = 1'b0;
      end
      m_if = newif; m_hist = req; m_ack = hi;
    end
  endtask

  task automatic check_all();
    logic [7:0] eb;
    logic       es;
    es = addr_out && (addr == 16'hFF0F || addr == 16'hFFFF);
    eb = 8'h00;
    if (addr_out && bus_in && addr == 16'hFF0F) eb = {3'b111, m_if};
    else if (addr_out && bus_in && addr == 16'hFFFF) eb = m_ie;
    check("o_Interrupts", 16'(ints), 16'(m_if & m_ie[4:0]));
    check("o_Vector", vec, m_vec);
    check("o_Vector_Valid", 16'(vv), 16'(m_vv));
    check("o_Bus", 16'(rdata), 16'(eb));
    check("o_Selected", 16'(sel), 16'(es));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    addr_out = 0; bus_out = 0; bus_in = 0; addr = 16'h0000; wdata = 8'h00;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; addr_out = 1; bus_out = 1; bus_in = 0; wdata = d;
    cycle();
    idle();
  endtask

  task automatic peek(input logic [15:0] a, input string tag, input logic [7:0] exp);
    addr = a; addr_out = 1; bus_out = 0; bus_in = 1;
    #1;
    check(tag, 16'(rdata), 16'(exp));
    check_all();
    idle();
  endtask

  initial begin
    idle();
    rst = 1; en = 1; req = 0; hi = 0;
    m_if = 0; m_ie = 0; m_hist = 0; m_ack = 0; m_vec = 0; m_vv = 0;
    cycle();
    rst = 0;

    // Reset state reads
    peek(16'hFF0F, "rd_if_reset", 8'hE0);
    addr = 16'hFF0F; addr_out = 1; bus_in = 1; #1;
    check("sel_if", 16'(sel), 16'h1);
    idle();
    peek(16'hFFFF, "rd_ie_reset", 8'h00);
    peek(16'hC000, "rd_other", 8'h00);
    addr = 16'hC000; addr_out = 1; #1;
    check("sel_other", 16'(sel), 16'h0);
    idle();

    // Held request sets IF only once
    wr(16'hFFFF, 8'h1F);
    req = 5'b00100;
    repeat (3) cycle();
    req = 0;
    cycle();
    check("ints_timer", 16'(ints), 16'h0004);
    peek(16'hFF0F, "rd_if_timer", 8'hE4);

    // Dispatch picks lowest pending-enabled bit
    wr(16'hFF0F, 8'h16);
    wr(16'hFFFF, 8'h14);
    hi = 1;
    cycle();
    check("vec_50", vec, 16'h0050);
    check("vv_set", 16'(vv), 16'h1);
    peek(16'hFF0F, "rd_if_acked", 8'hF2);
    repeat (4) cycle();
    check("vec_hold", vec, 16'h0050);
    hi = 0;
    cycle();
    check("vv_clear", 16'(vv), 16'h0);

    // Cancelled dispatch
    wr(16'hFFFF, 8'h00);
    wr(16'hFF0F, 8'h01);
    hi = 1;
    cycle();
    check("vec_cancel", vec, 16'h0000);
    check("vv_cancel", 16'(vv), 16'h1);
    peek(16'hFF0F, "rd_if_cancel", 8'hE1);
    hi = 0;
    cycle();

    // Request edge beats CPU write of IF
    req = 5'b00001;
    wr(16'hFF0F, 8'h00);
    peek(16'hFF0F, "rd_if_wr_vs_req", 8'hE1);
    req = 0;
    cycle();

    // Request edge beats ack clear
    wr(16'hFF0F, 8'h02);
    wr(16'hFFFF, 8'h02);
    hi = 1; req = 5'b00010;
    cycle();
    check("vec_48", vec, 16'h0048);
    peek(16'hFF0F, "rd_if_ack_vs_req", 8'hE2);
    hi = 0; req = 0;
    cycle();

    // Reset mid-dispatch while disabled
    hi = 1;
    cycle();
    en = 0; rst = 1;
    cycle();
    check("vv_rst", 16'(vv), 16'h0);
    check("vec_rst", vec, 16'h0000);
    peek(16'hFF0F, "rd_if_rst", 8'hE0);
    rst = 0; en = 1;
    cycle();
    check("vv_rerise", 16'(vv), 16'h1);
    hi = 0;
    cycle();

    // Edge arriving while disabled is captured later
    en = 0; req = 5'b01000;
    repeat (2) cycle();
    peek(16'hFF0F, "rd_if_disabled", 8'hE0);
    en = 1;
    cycle();
    peek(16'hFF0F, "rd_if_enabled", 8'hE8);
    req = 0;
    cycle();

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      en       = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: addr = 16'hFF0F;
        1: addr = 16'hFFFF;
        default: addr = 16'($urandom);
      endcase
      addr_out = $urandom_range(0, 1);
      bus_out  = ($urandom_range(0, 3) == 0);
      bus_in   = $urandom_range(0, 1);
      wdata    = 8'($urandom);
      if ($urandom_range(0, 2) == 0) req = 5'($urandom);
      if ($urandom_range(0, 3) == 0) hi = ~hi;
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
